// File: rtl/uart_tx_frame_ctrl.sv
// rtl/uart_tx_frame_ctrl.sv - parametrised UART TX frame engine (start, data, parity, 1/2 stop bits)
// Optional line-break generation is compiled in with UART_TX_BREAK_EN.
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int BREAK_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  baud_tick,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  par_en,
  input  logic                  par_odd,
  input  logic                  stop2,
`ifdef UART_TX_BREAK_EN
  input  logic                  send_break,
`endif
  output logic                  tx_out,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
`ifdef UART_TX_BREAK_EN
    , S_BREAK = 3'd6
`endif
  } state_e;

  state_e                state_q, state_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d;

`ifdef UART_TX_BREAK_EN
  localparam int BRK_CW = $clog2(BREAK_LEN + 1);
  localparam logic [BRK_CW-1:0] BRK_LAST = BRK_CW'(BREAK_LEN - 1);
  logic              brk_q, brk_d;
  logic [BRK_CW-1:0] brk_cnt_q, brk_cnt_d;
`else
  localparam int unused_break_len = BREAK_LEN;
`endif

  logic idle_ready;
  logic last_stop;
  logic xfer;

`ifdef UART_TX_BREAK_EN
  assign idle_ready = (state_q == S_IDLE) && !send_break;
`else
  assign idle_ready = (state_q == S_IDLE);
`endif

  assign last_stop = !stop2_q || stop_cnt_q;
  // The final stop tick doubles as an accept slot so frames can run back to back.
  assign in_ready  = idle_ready || ((state_q == S_STOP) && last_stop && baud_tick);
  assign xfer      = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
`ifdef UART_TX_BREAK_EN
    brk_d      = brk_q;
    brk_cnt_d  = brk_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
`ifdef UART_TX_BREAK_EN
        if (send_break) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
          brk_d   = 1'b1;
        end else
`endif
        if (xfer) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        if (baud_tick) begin
          tx_d = 1'b0;
`ifdef UART_TX_BREAK_EN
          if (brk_q) begin
            state_d   = S_BREAK;
            brk_cnt_d = '0;
          end else begin
            state_d = S_START;
          end
`else
          state_d = S_START;
`endif
        end
      end
      S_START: begin
        if (baud_tick) begin
          tx_d      = shreg_q[0];
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q != LAST_BIT) begin
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shreg_q[1];
          end else if (par_en_q) begin
            tx_d    = par_bit_q;
            state_d = S_PARITY;
          end else begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (!last_stop) begin
            stop_cnt_d = 1'b1;
          end else begin
            done_d = 1'b1;
            if (xfer) begin
              tx_d    = 1'b0;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        if (baud_tick) begin
          if (brk_cnt_q == BRK_LAST) begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            stop2_d    = stop2;
            brk_d      = 1'b0;
            state_d    = S_STOP;
          end else begin
            brk_cnt_d = brk_cnt_q + 1'b1;
          end
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Frame attributes are captured only at the handshake; later input changes are ignored.
    if (xfer) begin
      shreg_d   = in_data;
      par_en_d  = par_en;
      par_bit_d = (^in_data) ^ par_odd;
      stop2_d   = stop2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_q      <= 1'b0;
      brk_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
`ifdef UART_TX_BREAK_EN
      brk_q      <= brk_d;
      brk_cnt_q  <= brk_cnt_d;
`endif
    end
  end

  assign tx_out  = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb/tb_uart_tx_frame_ctrl.sv - directed bench for uart_tx_frame_ctrl, baud tick every 4 clocks
// Break scenario is included when UART_TX_BREAK_EN is defined.
module tb_uart_tx_frame_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          baud_tick = 1'b0;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          par_en;
  logic          par_odd;
  logic          stop2;
  logic          tx_out;
  logic          busy;
  logic          tx_done;
`ifdef UART_TX_BREAK_EN
  logic          send_break;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int tick_ph = 0;

  uart_tx_frame_ctrl #(.DATA_WIDTH(DW), .BREAK_LEN(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_tick (baud_tick),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .par_en    (par_en),
    .par_odd   (par_odd),
    .stop2     (stop2),
`ifdef UART_TX_BREAK_EN
    .send_break(send_break),
`endif
    .tx_out    (tx_out),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    tick_ph   = (tick_ph + 1) % 4;
    baud_tick = (tick_ph == 0);
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (tx_done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Returns #1 after the next clock edge that sees baud_tick; rdy is in_ready just before it.
  task automatic wait_tick(output logic rdy);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (baud_tick !== 1'b1 && n < 16);
    n_cmp++;
    assert (n < 16) else begin
      n_err++;
      $error("FAIL tick_timeout: observed %0d cycles expected below 16", n);
    end
    rdy = in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic pe, input logic po,
                      input logic s2, input logic align);
    int n = 0;
    in_data = d;
    par_en  = pe;
    par_odd = po;
    stop2   = s2;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(in_ready === 1'b1 && (!align || baud_tick === 1'b1)) && n < 40);
    n_cmp++;
    assert (n < 40) else begin
      n_err++;
      $error("FAIL handshake_timeout: observed in_ready=%b expected 1", in_ready);
    end
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int first, input int n, input logic [31:0] exp);
    logic [31:0] got = '0;
    logic [31:0] mask = '0;
    logic        r;
    for (int i = first; i < first + n; i++) begin
      wait_tick(r);
      got[i]  = tx_out;
      mask[i] = 1'b1;
    end
    check(tag, got, exp & mask);
  endtask

  task automatic frame_end(input string tag, input int done_exp);
    logic r;
    wait_tick(r);
    check1({tag, "_done_hi"}, tx_done, 1'b1);
    check1({tag, "_busy_lo"}, busy, 1'b0);
    check1({tag, "_tx_idle"}, tx_out, 1'b1);
    @(posedge clk);
    #1;
    check1({tag, "_done_lo"}, tx_done, 1'b0);
    check({tag, "_done_cnt"}, done_cnt, done_exp);
  endtask

  initial begin
    int   d0;
    logic r;
    in_data  = '0;
    in_valid = 1'b0;
    par_en   = 1'b0;
    par_odd  = 1'b0;
    stop2    = 1'b0;
`ifdef UART_TX_BREAK_EN
    send_break = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check1("rst_tx", tx_out, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", tx_done, 1'b0);
    check1("rst_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // 0xA5, 8N1
    d0 = done_cnt;
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    check1("t1_load_tx", tx_out, 1'b1);
    check1("t1_load_busy", busy, 1'b1);
    check1("t1_load_ready", in_ready, 1'b0);
    collect("t1_frame", 0, 10, 32'h34A);
    frame_end("t1", d0 + 1);

    // 0x07 with even parity (handshake on a tick edge), then odd parity
    d0 = done_cnt;
    send(8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
    check1("t2_align_tx", tx_out, 1'b1);
    collect("t2_even", 0, 11, 32'h60E);
    frame_end("t2e", d0 + 1);
    send(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    collect("t2_odd", 0, 11, 32'h40E);
    frame_end("t2o", d0 + 2);

    // Back-to-back 0x55, 0xAA with two stop bits
    d0 = done_cnt;
    in_data  = 8'h55;
    par_en   = 1'b0;
    stop2    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_data = 8'hAA;
    collect("t3_f1", 0, 11, 32'h6AA);
    check1("t3_busy_mid", busy, 1'b1);
    wait_tick(r);
    in_valid = 1'b0;
    check1("t3_b2b_ready", r, 1'b1);
    check1("t3_b2b_start", tx_out, 1'b0);
    check1("t3_b2b_busy", busy, 1'b1);
    check1("t3_b2b_done", tx_done, 1'b1);
    collect("t3_f2", 1, 10, 32'h754);
    frame_end("t3", d0 + 2);
    stop2 = 1'b0;

    // Asynchronous reset while a low data bit is on the line
    send(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    collect("t4_pre", 0, 5, 32'h0);
    @(negedge clk);
    #1;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check1("t4_rst_tx", tx_out, 1'b1);
    check1("t4_rst_busy", busy, 1'b0);
    check1("t4_rst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    collect("t4_frame", 0, 10, 32'h278);
    frame_end("t4", d0 + 1);

    // Offer a new payload and wiggle in_data while the frame is in DATA
    d0 = done_cnt;
    send(8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
    collect("t5_a", 0, 3, 32'h32C);
    in_valid = 1'b1;
    in_data  = 8'h69;
    #1;
    check1("t5_busy_ready", in_ready, 1'b0);
    @(negedge clk);
    in_data = ~in_data;
    @(negedge clk);
    in_data  = 8'hFF;
    in_valid = 1'b0;
    collect("t5_b", 3, 7, 32'h32C);
    frame_end("t5", d0 + 1);
    repeat (8) @(posedge clk);
    #1;
    check1("t5_stays_idle", busy, 1'b0);

`ifdef UART_TX_BREAK_EN
    // Break wins over a pending payload; payload follows right after the break's stop bit
    d0 = done_cnt;
    in_data    = 8'h81;
    par_en     = 1'b0;
    stop2      = 1'b0;
    in_valid   = 1'b1;
    send_break = 1'b1;
    #1;
    check1("t6_break_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    send_break = 1'b0;
    check1("t6_busy", busy, 1'b1);
    check1("t6_load_ready", in_ready, 1'b0);
    collect("t6_break", 0, 17, 32'h10000);
    wait_tick(r);
    in_valid = 1'b0;
    check1("t6_accept", r, 1'b1);
    check1("t6_start", tx_out, 1'b0);
    check1("t6_done", tx_done, 1'b1);
    collect("t6_frame", 1, 9, 32'h302);
    frame_end("t6", d0 + 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
